// File: rtl/logic_gate_pkg.sv
// Shared definitions for the bitwise gate pipeline: op encoding, FSM states
// and the per-bit base operation used by the ALU.
package logic_gate_pkg;

  localparam logic [1:0] OP_AND  = 2'd0;
  localparam logic [1:0] OP_OR   = 2'd1;
  localparam logic [1:0] OP_XOR  = 2'd2;
  localparam logic [1:0] OP_PASS = 2'd3;
  localparam int         OP_INV_BIT = 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  // PASS returns the first operand so a chain under PASS keeps its first value.
  function automatic logic base_bit(input logic a, input logic b, input logic [1:0] op);
    case (op)
      OP_AND:  base_bit = a & b;
      OP_OR:   base_bit = a | b;
      OP_XOR:  base_bit = a ^ b;
      default: base_bit = a;
    endcase
  endfunction

endpackage

// File: rtl/logic_gate_alu.sv
// Combinational bitwise operator: y = base(a, b) for op[1:0].
module logic_gate_alu
  import logic_gate_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    for (int i = 0; i < WIDTH; i++) begin
      y[i] = base_bit(a[i], b[i], op);
    end
  end

endmodule

// File: rtl/logic_gate_pipe.sv
// Chained bitwise gate pipeline with a one-deep registered result.
// Optional beat counter output enabled by LOGIC_GATE_PIPE_BEATCNT_EN.
//
// state   | meaning
// S_IDLE  | no chain open, no result held
// S_ACCUM | chain open, acc holds the partial result
// S_FULL  | result held on out until consumed
module logic_gate_pipe
  import logic_gate_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [2:0]       op,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out
`ifdef LOGIC_GATE_PIPE_BEATCNT_EN
  ,
  output logic [7:0]       out_beats
`endif
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] out_q;
  logic             accept;
  logic             first;
  logic [2:0]       op_eff;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_y;

  // Any beat accepted outside ACCUM starts a new chain, including the
  // beat that arrives in the same cycle the held result is consumed.
  always_comb begin
    in_ready = (state_q != S_FULL) || out_ready;
    accept   = in_valid && in_ready;
    first    = (state_q != S_ACCUM);
    op_eff   = first ? op : op_q;
    alu_a    = first ? in0 : acc_q;
    state_d  = state_q;
    case (state_q)
      S_IDLE, S_ACCUM: begin
        if (accept) state_d = in_last ? S_FULL : S_ACCUM;
      end
      S_FULL: begin
        if (accept)         state_d = in_last ? S_FULL : S_ACCUM;
        else if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  logic_gate_alu #(.WIDTH(WIDTH)) u_alu (
    .a  (alu_a),
    .b  (in1),
    .op (op_eff[1:0]),
    .y  (alu_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      op_q    <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        acc_q <= alu_y;
        if (first)   op_q  <= op;
        if (in_last) out_q <= op_eff[OP_INV_BIT] ? ~alu_y : alu_y;
      end
    end
  end

  assign out_valid = (state_q == S_FULL);
  assign out       = out_q;

`ifdef LOGIC_GATE_PIPE_BEATCNT_EN
  logic [7:0] cnt_q, cnt_d, beats_q;

  always_comb begin
    if (first)               cnt_d = 8'd1;
    else if (cnt_q == 8'hFF) cnt_d = 8'hFF;
    else                     cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      beats_q <= '0;
    end else if (accept) begin
      cnt_q <= cnt_d;
      if (in_last) beats_q <= cnt_d;
    end
  end

  assign out_beats = beats_q;
`endif

endmodule

// File: tb/tb_logic_gate_pipe.sv
// Directed self-checking bench for logic_gate_pipe (WIDTH=8); inputs change
// and outputs are sampled on the falling clock edge.
module tb_logic_gate_pipe;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in0;
  logic [7:0] in1;
  logic [2:0] op;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out;
`ifdef LOGIC_GATE_PIPE_BEATCNT_EN
  logic [7:0] out_beats;
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic_gate_pipe #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in0       (in0),
    .in1       (in1),
    .op        (op),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out)
`ifdef LOGIC_GATE_PIPE_BEATCNT_EN
    ,
    .out_beats (out_beats)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    string      name;
    logic [2:0] op;
    logic [7:0] in0;
    logic [7:0] in1;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  // Caller is at a falling edge; offers the beat and advances to the next falling edge.
  task automatic beat(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b, input logic last);
    in_valid = 1'b1;
    op       = o;
    in0      = a;
    in1      = b;
    in_last  = last;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic idle_cycle();
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    tbl[0] = '{"or_single", 3'd1, 8'h0F, 8'hF0, 8'hFF};
    tbl[1] = '{"and",  3'd0, 8'hCC, 8'hAA, 8'h88};
    tbl[2] = '{"or",   3'd1, 8'hCC, 8'hAA, 8'hEE};
    tbl[3] = '{"xor",  3'd2, 8'hCC, 8'hAA, 8'h66};
    tbl[4] = '{"pass", 3'd3, 8'hCC, 8'hAA, 8'hCC};
    tbl[5] = '{"nand", 3'd4, 8'hCC, 8'hAA, 8'h77};
    tbl[6] = '{"nor",  3'd5, 8'hCC, 8'hAA, 8'h11};
    tbl[7] = '{"xnor", 3'd6, 8'hCC, 8'hAA, 8'h99};
    tbl[8] = '{"not",  3'd7, 8'hCC, 8'hAA, 8'h33};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in0       = '0;
    in1       = '0;
    op        = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    #1;
    chk1("reset_out_valid", out_valid, 1'b0);
    chk("reset_out", out, 8'h00);
    chk1("reset_in_ready", in_ready, 1'b1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single-beat table: result valid the next cycle, for exactly one cycle.
    for (int i = 0; i < 9; i++) begin
      beat(tbl[i].op, tbl[i].in0, tbl[i].in1, 1'b1);
      chk1({tbl[i].name, "_valid"}, out_valid, 1'b1);
      chk(tbl[i].name, out, tbl[i].exp);
      idle_cycle();
      chk1({tbl[i].name, "_one_cycle"}, out_valid, 1'b0);
    end

    // Three-beat AND chain; later op values must be ignored.
    beat(3'd0, 8'hFF, 8'hF0, 1'b0);
    chk1("chain_no_early_valid1", out_valid, 1'b0);
    chk1("chain_ready1", in_ready, 1'b1);
    beat(3'd1, 8'h00, 8'h3C, 1'b0);
    chk1("chain_no_early_valid2", out_valid, 1'b0);
    beat(3'd2, 8'h00, 8'h18, 1'b1);
    chk1("chain_valid", out_valid, 1'b1);
    chk("chain_and", out, 8'h10);
`ifdef LOGIC_GATE_PIPE_BEATCNT_EN
    chk("chain_beats", out_beats, 8'd3);
`endif
    idle_cycle();

    // Backpressure: held result with a pending beat that must not be lost.
    out_ready = 1'b0;
    beat(3'd2, 8'h5A, 8'h0F, 1'b1);
    in_valid = 1'b1;
    op       = 3'd0;
    in0      = 8'hF0;
    in1      = 8'h3C;
    in_last  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      chk1("bp_valid", out_valid, 1'b1);
      chk("bp_hold", out, 8'h55);
      chk1("bp_in_ready", in_ready, 1'b0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk1("b2b_valid0", out_valid, 1'b1);
    chk("b2b_pending_beat", out, 8'h30);
    beat(3'd1, 8'h01, 8'h02, 1'b1);
    chk1("b2b_valid1", out_valid, 1'b1);
    chk("b2b_or", out, 8'h03);
    beat(3'd4, 8'hFF, 8'h0F, 1'b1);
    chk1("b2b_valid2", out_valid, 1'b1);
    chk("b2b_nand", out, 8'hF0);
    idle_cycle();
    chk1("b2b_drain", out_valid, 1'b0);

    // Reset after two of three beats discards the chain.
    beat(3'd1, 8'h11, 8'h22, 1'b0);
    beat(3'd1, 8'h00, 8'h44, 1'b0);
    rst_n = 1'b0;
    #1;
    chk1("rst_mid_valid", out_valid, 1'b0);
    chk("rst_mid_out", out, 8'h00);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    chk1("rst_nothing_emitted", out_valid, 1'b0);
    beat(3'd2, 8'h01, 8'h03, 1'b1);
    chk1("rst_after_valid", out_valid, 1'b1);
    chk("rst_after_xor", out, 8'h02);
    idle_cycle();

`ifdef LOGIC_GATE_PIPE_BEATCNT_EN
    // 300-beat OR chain: counter saturates.
    for (int k = 0; k < 300; k++) begin
      beat(3'd1, 8'h01, (k == 150) ? 8'h80 : 8'h00, (k == 299) ? 1'b1 : 1'b0);
    end
    chk1("sat_valid", out_valid, 1'b1);
    chk("sat_out", out, 8'h81);
    chk("sat_beats", out_beats, 8'd255);
    idle_cycle();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
